// File: rtl/serial_frame_pkg.sv
// Shared types and defaults for the serial divisibility frame controller.
package serial_frame_pkg;

  // Frame controller states. The encoding is also exported on a debug port.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    RESULT  = 2'd3
  } frame_state_t;

  // Default word width fed to the serial checker.
  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/msb_first_shift_reg.sv
// Parallel-load shift register presenting its word MSB-first, one bit per shift.
module msb_first_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             msb
);

  logic [WIDTH-1:0] r_data;

  // Load has priority over shift; zeros enter from the LSB end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= data;
    end else if (shift) begin
      r_data <= r_data << 1;
    end
  end

  assign msb = r_data[WIDTH-1];

endmodule

// File: rtl/serial_divisibility_frame_ctrl.sv
// Frame controller: accepts a parallel word, streams it MSB-first into a
// serial divisibility checker, then returns the checker's flag as a result.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE. Once res_valid rises, it and
// res_div hold steady until the edge where res_ready is also high.
module serial_divisibility_frame_ctrl
  import serial_frame_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             chk_rst,
  output logic             chk_bit,
  input  logic             chk_div,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_div,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  frame_state_t  r_state;
  logic [CW-1:0] r_cnt;
  logic          r_in_ready;
  logic          r_chk_rst;
  logic          r_res_valid;
  logic          r_res_div;

  logic          w_accept;
  logic          w_shift;
  logic          w_msb;

  assign w_accept = in_valid & r_in_ready;
  assign w_shift  = (r_state == SHIFT);

  msb_first_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (w_accept),
    .shift (w_shift),
    .data  (in_data),
    .msb   (w_msb)
  );

  // Frame FSM with registered handshake and checker-control outputs. The
  // checker has no enable, so chk_rst is held high everywhere except SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_chk_rst   <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_div   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= SHIFT;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_chk_rst  <= 1'b0;
          end
        end
        SHIFT: begin
          r_cnt <= r_cnt + CNT_ONE;
          if (r_cnt == LAST_CNT) begin
            r_state   <= CAPTURE;
            r_chk_rst <= 1'b1;
          end
        end
        CAPTURE: begin
          // Checker output reflects all WIDTH bits; it is cleared at this edge.
          r_res_div   <= chk_div;
          r_res_valid <= 1'b1;
          r_state     <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_chk_rst   <= 1'b1;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign chk_rst   = r_chk_rst;
  assign chk_bit   = ~r_chk_rst & w_msb;
  assign res_valid = r_res_valid;
  assign res_div   = r_res_div;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_divisibility_frame_ctrl.sv
// Bench for the frame controller, paired with a div-by-5 serial checker,
// in an 8-bit build and a 1-bit build.
module tb_serial_divisibility_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  // 8-bit instance
  logic       in_valid, in_ready, chk_rst, chk_bit, chk_div, res_valid, res_ready, res_div;
  logic [7:0] in_data;
  logic [1:0] dbg_state;
  logic [2:0] r_rem;

  // 1-bit instance
  logic       w1_in_valid, w1_in_ready, w1_chk_rst, w1_chk_bit, w1_chk_div;
  logic       w1_res_valid, w1_res_ready, w1_res_div;
  logic [0:0] w1_in_data;
  logic [1:0] w1_dbg_state;
  logic [2:0] w1_rem;

  logic [0:0] exp_q[$];
  int         last_acc = 0;

  serial_divisibility_frame_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .chk_rst(chk_rst), .chk_bit(chk_bit), .chk_div(chk_div), .res_valid(res_valid),
    .res_ready(res_ready), .res_div(res_div), .dbg_state(dbg_state)
  );

  serial_divisibility_frame_ctrl #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst(rst), .in_valid(w1_in_valid), .in_ready(w1_in_ready), .in_data(w1_in_data),
    .chk_rst(w1_chk_rst), .chk_bit(w1_chk_bit), .chk_div(w1_chk_div), .res_valid(w1_res_valid),
    .res_ready(w1_res_ready), .res_div(w1_res_div), .dbg_state(w1_dbg_state)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Div-by-5 serial checker: remainder of the MSB-first bit stream, sync reset.
  function automatic logic [2:0] next_rem(input logic [2:0] r, input logic b);
    return 3'((int'(r) * 2 + int'(b)) % 5);
  endfunction

  always @(posedge clk) begin
    r_rem  <= chk_rst    ? 3'd0 : next_rem(r_rem, chk_bit);
    w1_rem <= w1_chk_rst ? 3'd0 : next_rem(w1_rem, w1_chk_bit);
  end
  assign chk_div    = (r_rem == 3'd0);
  assign w1_chk_div = (w1_rem == 3'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Send one word on the 8-bit instance; hold res_ready low for 'stall' cycles.
  // exp_period > 0 checks the spacing between this accept and the previous one.
  task automatic run_word(input logic [7:0] w, input int stall, input int exp_period);
    int n;
    logic [0:0] exp_div;
    in_valid  = 1'b1;
    in_data   = w;
    res_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", in_ready, 1);
    if (exp_period > 0) check("word_period", cyc + 1 - last_acc, exp_period);
    last_acc = cyc + 1;
    exp_q.push_back((w % 5) == 0);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      check("shift_bit", chk_bit, w[7-k]);
      check("shift_chk_rst", chk_rst, 0);
      check("shift_in_ready", in_ready, 0);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    check("capture_chk_rst", chk_rst, 1);
    check("capture_chk_bit", chk_bit, 0);
    check("capture_res_valid", res_valid, 0);
    @(negedge clk);
    check("res_valid_rise", res_valid, 1);
    check("latency", cyc - last_acc, 9);
    check("queue_nonempty", exp_q.size() > 0, 1);
    exp_div = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
    check("res_div", res_div, exp_div);
    for (int s = 0; s < stall; s++) begin
      check("stall_res_valid", res_valid, 1);
      check("stall_res_div", res_div, exp_div);
      check("stall_in_ready", in_ready, 0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    check("pre_consume_valid", res_valid, 1);
    in_valid = 1'b0;
    @(negedge clk);
    check("post_consume_valid", res_valid, 0);
    check("post_consume_ready", in_ready, 1);
    check("idle_chk_rst", chk_rst, 1);
  endtask

  // Send one word on the 1-bit instance.
  task automatic run_w1(input logic w, input logic exp_div);
    int n;
    int acc;
    w1_in_valid = 1'b1;
    w1_in_data  = w;
    n = 0;
    while (!w1_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w1_accept_ready", w1_in_ready, 1);
    acc = cyc + 1;
    @(negedge clk);
    w1_in_valid = 1'b0;
    check("w1_shift_bit", w1_chk_bit, w);
    check("w1_shift_state", w1_dbg_state, 1);
    @(negedge clk);
    check("w1_capture_state", w1_dbg_state, 2);
    @(negedge clk);
    check("w1_res_valid", w1_res_valid, 1);
    check("w1_latency", cyc - acc, 2);
    check("w1_res_div", w1_res_div, exp_div);
    @(negedge clk);
    check("w1_consumed", w1_res_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int seen;
    int prev_stall;
    logic [7:0] w;
    int stall;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    res_ready    = 1'b1;
    w1_in_valid  = 1'b0;
    w1_in_data   = '0;
    w1_res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_chk_rst", chk_rst, 1);
    check("rst_chk_bit", chk_bit, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_div", res_div, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed words
    run_word(8'd25, 0, 0);
    run_word(8'd26, 0, 0);
    run_word(8'd7, 0, 11);
    run_word(8'd0, 0, 11);
    run_word(8'd255, 0, 11);
    run_word(8'd10, 5, 11);
    idle(2);

    // Reset during the 4th SHIFT cycle of word 9
    in_valid = 1'b1;
    in_data  = 8'd9;
    exp_q.push_back(1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_shift", dbg_state, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_state", dbg_state, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_chk_rst", chk_rst, 1);
    check("abort_chk_bit", chk_bit, 0);
    check("abort_res_valid", res_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("abort_no_result", seen, 0);
    run_word(8'd15, 0, 0);

    // 1-bit build
    run_w1(1'b0, 1'b1);
    run_w1(1'b1, 1'b0);

    // Randomized words, stalls and gaps
    prev_stall = 0;
    for (int i = 0; i < 24; i++) begin
      w     = 8'($urandom_range(0, 255));
      stall = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        idle($urandom_range(1, 3));
        run_word(w, stall, 0);
      end else begin
        run_word(w, stall, (i == 0) ? 0 : 11 + prev_stall);
      end
      prev_stall = stall;
    end

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
